// File: rtl/field_line_clear.sv
// Line-clear engine: scans the playfield bottom-up for full rows, moves everything
// above each full row down by one, blanks row 0, and reports how many rows went.
module field_line_clear #(
    parameter int unsigned FIELD_COLS = 12,
    parameter int unsigned FIELD_ROWS = 22
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic [2:0] o_lines,
    output logic       o_line_remove_pls,
    output logic [8:0] o_ram_addr,
    input  logic [3:0] i_ram_rdata,
    output logic       o_ram_we,
    output logic [3:0] o_ram_wdata
);

    localparam int unsigned COL_W = $clog2(FIELD_COLS);
    localparam int unsigned ROW_W = $clog2(FIELD_ROWS);

    localparam logic [COL_W-1:0] COL_ZERO   = COL_W'(0);
    localparam logic [COL_W-1:0] COL_ONE    = COL_W'(1);
    localparam logic [COL_W-1:0] COL_TWO    = COL_W'(2);
    localparam logic [COL_W-1:0] X_LAST     = COL_W'(FIELD_COLS - 2);
    localparam logic [ROW_W-1:0] ROW_ZERO   = ROW_W'(0);
    localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_TWO    = ROW_W'(2);
    localparam logic [ROW_W-1:0] ROW_BOTTOM = ROW_W'(FIELD_ROWS - 2);

    typedef enum logic [2:0] {
        IDLE, SCAN, CHECK, SHIFT_RD, SHIFT_WR, CLEAR_TOP, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] dst_q, dst_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             occ_q, occ_d;
    logic             full_q, full_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       lines_d;
    logic             busy_d, done_d, pls_d, we_d;
    logic [8:0]       addr_d;
    logic [3:0]       wdata_d;

    function automatic logic [8:0] cell_addr(input logic [ROW_W-1:0] y, input logic [COL_W-1:0] x);
        return 9'(32'(y) * FIELD_COLS + 32'(x));
    endfunction

    // Next state and next values of every registered output
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        dst_d   = dst_q;
        col_d   = col_q;
        occ_d   = occ_q;
        full_d  = full_q;
        cnt_d   = cnt_q;
        lines_d = o_lines;
        done_d  = 1'b0;
        pls_d   = 1'b0;
        we_d    = 1'b0;
        wdata_d = 4'd0;
        addr_d  = o_ram_addr;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = SCAN;
                    row_d   = ROW_BOTTOM;
                    cnt_d   = 3'd0;
                    col_d   = COL_ZERO;
                    full_d  = 1'b1;
                    addr_d  = cell_addr(ROW_BOTTOM, COL_ONE);
                end
            end
            // col_q counts scan cycles; read data is registered into occ_q, ANDed a cycle later
            SCAN: begin
                occ_d = (i_ram_rdata != 4'd0);
                if (col_q != COL_ZERO) full_d = full_q & occ_q;
                if (col_q < X_LAST - COL_ONE) addr_d = cell_addr(row_q, col_q + COL_TWO);
                if (col_q == X_LAST) begin
                    pls_d   = full_q & occ_q;
                    state_d = CHECK;
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end
            CHECK: begin
                if (full_q) begin
                    if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
                    dst_d = row_q;
                    col_d = COL_ONE;
                    if (row_q == ROW_ZERO) begin
                        state_d = CLEAR_TOP;
                        we_d    = 1'b1;
                        addr_d  = cell_addr(ROW_ZERO, COL_ONE);
                    end else begin
                        state_d = SHIFT_RD;
                        addr_d  = cell_addr(row_q - ROW_ONE, COL_ONE);
                    end
                end else if (row_q == ROW_ZERO) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    lines_d = cnt_q;
                end else begin
                    state_d = SCAN;
                    row_d   = row_q - ROW_ONE;
                    col_d   = COL_ZERO;
                    full_d  = 1'b1;
                    addr_d  = cell_addr(row_q - ROW_ONE, COL_ONE);
                end
            end
            SHIFT_RD: begin
                state_d = SHIFT_WR;
                we_d    = 1'b1;
                wdata_d = i_ram_rdata;
                addr_d  = cell_addr(dst_q, col_q);
            end
            SHIFT_WR: begin
                state_d = SHIFT_RD;
                if (col_q != X_LAST) begin
                    col_d  = col_q + COL_ONE;
                    addr_d = cell_addr(dst_q - ROW_ONE, col_q + COL_ONE);
                end else if (dst_q != ROW_ONE) begin
                    dst_d  = dst_q - ROW_ONE;
                    col_d  = COL_ONE;
                    addr_d = cell_addr(dst_q - ROW_TWO, COL_ONE);
                end else begin
                    state_d = CLEAR_TOP;
                    col_d   = COL_ONE;
                    we_d    = 1'b1;
                    addr_d  = cell_addr(ROW_ZERO, COL_ONE);
                end
            end
            // Same row is rescanned afterwards since new content dropped into it
            CLEAR_TOP: begin
                if (col_q != X_LAST) begin
                    col_d  = col_q + COL_ONE;
                    we_d   = 1'b1;
                    addr_d = cell_addr(ROW_ZERO, col_q + COL_ONE);
                end else begin
                    state_d = SCAN;
                    col_d   = COL_ZERO;
                    full_d  = 1'b1;
                    addr_d  = cell_addr(row_q, COL_ONE);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            state_q           <= IDLE;
            row_q             <= ROW_ZERO;
            dst_q             <= ROW_ZERO;
            col_q             <= COL_ZERO;
            occ_q             <= 1'b0;
            full_q            <= 1'b0;
            cnt_q             <= 3'd0;
            o_lines           <= 3'd0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_line_remove_pls <= 1'b0;
            o_ram_we          <= 1'b0;
            o_ram_addr        <= 9'd0;
            o_ram_wdata       <= 4'd0;
        end else begin
            state_q           <= state_d;
            row_q             <= row_d;
            dst_q             <= dst_d;
            col_q             <= col_d;
            occ_q             <= occ_d;
            full_q            <= full_d;
            cnt_q             <= cnt_d;
            o_lines           <= lines_d;
            o_busy            <= busy_d;
            o_done            <= done_d;
            o_line_remove_pls <= pls_d;
            o_ram_we          <= we_d;
            o_ram_addr        <= addr_d;
            o_ram_wdata       <= wdata_d;
        end
    end

endmodule

// File: tb/tb_field_line_clear.sv
// Self-checking bench for field_line_clear: a field RAM model plus a row-filter
// reference that predicts final contents, pulse/write counts and done latency.
module tb_field_line_clear;

    localparam int COLS      = 12;
    localparam int ROWS      = 22;
    localparam int INNER     = COLS - 2;
    localparam int NCELL     = COLS * ROWS;
    localparam int LAT_LIMIT = 20000;

    logic       i_clk = 1'b0;
    logic       i_res = 1'b0;
    logic       i_start = 1'b0;
    logic       o_busy, o_done, o_line_remove_pls, o_ram_we;
    logic [2:0] o_lines;
    logic [8:0] o_ram_addr;
    logic [3:0] i_ram_rdata, o_ram_wdata;

    logic [3:0] mem    [NCELL];
    logic [3:0] init_f [NCELL];
    logic       load_now = 1'b0;

    int pulses = 0, writes = 0, bad_writes = 0, dones = 0;
    int n_tests = 0, n_fail = 0;

    field_line_clear #(.FIELD_COLS(COLS), .FIELD_ROWS(ROWS)) dut (
        .i_clk             (i_clk),
        .i_res             (i_res),
        .i_start           (i_start),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_lines           (o_lines),
        .o_line_remove_pls (o_line_remove_pls),
        .o_ram_addr        (o_ram_addr),
        .i_ram_rdata       (i_ram_rdata),
        .o_ram_we          (o_ram_we),
        .o_ram_wdata       (o_ram_wdata)
    );

    always #5 i_clk = ~i_clk;

    // Field RAM: read data follows the registered address, writes land on the edge
    assign i_ram_rdata = (int'(o_ram_addr) < NCELL) ? mem[o_ram_addr] : 4'd0;

    always @(posedge i_clk) begin
        if (load_now) begin
            for (int i = 0; i < NCELL; i++) mem[i] <= init_f[i];
        end else if (o_ram_we && int'(o_ram_addr) < NCELL) begin
            mem[o_ram_addr] <= o_ram_wdata;
        end
    end

    always @(negedge i_clk) begin
        if (o_line_remove_pls === 1'b1) pulses++;
        if (o_done === 1'b1) dones++;
        if (o_ram_we === 1'b1) begin
            writes++;
            if ((int'(o_ram_addr) % COLS) == 0 || (int'(o_ram_addr) % COLS) == COLS - 1 ||
                (int'(o_ram_addr) / COLS) >= ROWS - 1)
                bad_writes++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic make_base();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                init_f[y*COLS+x] = (x == 0 || x == COLS-1 || y == ROWS-1) ?
                                   4'($urandom_range(1, 15)) : 4'd0;
    endtask

    // kind: 0 empty, 1 full, 2 partial (at least one hole)
    task automatic set_row(input int y, input int kind);
        for (int x = 1; x <= INNER; x++)
            init_f[y*COLS+x] = (kind == 0) ? 4'd0 :
                               (kind == 1) ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
        if (kind == 2) init_f[y*COLS + int'($urandom_range(1, INNER))] = 4'd0;
    endtask

    task automatic random_field();
        make_base();
        for (int y = 0; y < ROWS-1; y++)
            set_row(y, ($urandom_range(0, 9) < 3) ? 1 : int'($urandom_range(0, 1)) * 2);
    endtask

    function automatic bit row_is_full(input int y);
        for (int x = 1; x <= INNER; x++)
            if (init_f[y*COLS+x] == 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load_field();
        @(negedge i_clk) load_now = 1'b1;
        @(negedge i_clk) load_now = 1'b0;
    endtask

    task automatic run_case(input string name, input bit repulse);
        int kept[$];
        int nfull, exp_lat, exp_writes, lat, r, mism, p0, w0, b0, d0;
        logic [2:0] lines_at_done;
        logic [3:0] expf [NCELL];

        // Reference: full rows vanish, surviving rows settle to the bottom in order
        nfull = 0; exp_writes = 0;
        exp_lat = (ROWS - 1) * 12;
        for (int k = ROWS-2; k >= 0; k--) begin
            if (row_is_full(k)) begin
                r = k + nfull;
                exp_lat    += 2 * INNER * r + 12 + INNER;
                exp_writes += INNER * (r + 1);
                nfull++;
            end else begin
                kept.push_back(k);
            end
        end
        for (int i = 0; i < NCELL; i++) expf[i] = init_f[i];
        for (int d = ROWS-2; d >= 0; d--) begin
            int s;
            s = ROWS - 2 - d;
            for (int x = 1; x <= INNER; x++)
                expf[d*COLS+x] = (s < kept.size()) ? init_f[kept[s]*COLS+x] : 4'd0;
        end

        load_field();
        p0 = pulses; w0 = writes; b0 = bad_writes; d0 = dones;
        i_start = 1'b1;
        @(negedge i_clk) i_start = 1'b0;
        lat = 0;
        while (o_done !== 1'b1 && lat < LAT_LIMIT) begin
            @(negedge i_clk);
            lat++;
            i_start = repulse && (lat % 37 == 5);
        end
        i_start = 1'b0;
        lines_at_done = o_lines;
        check({name, ".done_lat"}, lat, exp_lat);
        check({name, ".busy_in_done"}, o_busy, 1);
        check({name, ".lines"}, lines_at_done, (nfull > 7) ? 7 : nfull);
        @(negedge i_clk);
        check({name, ".done_one_cycle"}, o_done, 0);
        check({name, ".idle_busy"}, o_busy, 0);
        check({name, ".lines_hold"}, o_lines, (nfull > 7) ? 7 : nfull);
        check({name, ".pulses"}, pulses - p0, nfull);
        check({name, ".writes"}, writes - w0, exp_writes);
        check({name, ".bad_writes"}, bad_writes - b0, 0);
        check({name, ".done_count"}, dones - d0, 1);
        mism = 0;
        for (int i = 0; i < NCELL; i++) if (mem[i] !== expf[i]) mism++;
        check({name, ".ram_cells_wrong"}, mism, 0);
        if (lat >= LAT_LIMIT) begin
            @(negedge i_clk) i_res = 1'b1;
            @(negedge i_clk) i_res = 1'b0;
        end
    endtask

    initial begin
        int lat, d0;

        #1 i_res = 1'b1;
        @(negedge i_clk);
        check("rst.busy", o_busy, 0);
        check("rst.done", o_done, 0);
        check("rst.lines", o_lines, 0);
        check("rst.pls", o_line_remove_pls, 0);
        check("rst.we", o_ram_we, 0);
        check("rst.addr", o_ram_addr, 0);
        check("rst.wdata", o_ram_wdata, 0);
        @(negedge i_clk) i_res = 1'b0;

        make_base();
        run_case("empty", 1'b0);

        make_base(); set_row(20, 1); set_row(19, 2);
        run_case("one_line", 1'b0);

        make_base(); for (int y = 17; y <= 20; y++) set_row(y, 1);
        run_case("four_lines", 1'b0);

        make_base(); set_row(20, 1); set_row(19, 2); set_row(18, 1); set_row(17, 2); set_row(16, 2);
        run_case("split_lines", 1'b0);

        make_base(); set_row(0, 1); set_row(5, 2); set_row(20, 2);
        run_case("top_row_full", 1'b0);

        make_base(); for (int y = 0; y < ROWS-1; y++) set_row(y, 1);
        run_case("all_full_sat", 1'b0);

        make_base(); set_row(20, 1); set_row(19, 2); set_row(18, 1); set_row(17, 2);
        run_case("repulse", 1'b1);

        // Reset in the middle of the first shift write
        make_base(); set_row(20, 1); set_row(19, 2); set_row(18, 2);
        load_field();
        i_start = 1'b1;
        @(negedge i_clk) i_start = 1'b0;
        lat = 0;
        while (o_ram_we !== 1'b1 && lat < 500) begin
            @(negedge i_clk);
            lat++;
        end
        check("mid_rst.we_reached", o_ram_we, 1);
        d0 = dones;
        #2 i_res = 1'b1;
        #1;
        check("mid_rst.we", o_ram_we, 0);
        check("mid_rst.busy", o_busy, 0);
        repeat (3) @(negedge i_clk);
        check("mid_rst.no_done", dones - d0, 0);
        i_res = 1'b0;
        @(negedge i_clk);
        check("mid_rst.idle", o_busy, 0);
        random_field();
        run_case("after_rst", 1'b0);

        for (int t = 0; t < 8; t++) begin
            random_field();
            run_case($sformatf("rand%0d", t), t[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/field_line_clear.md
FIELD_LINE_CLEAR -- requirements
Module: field_line_clear

Interface
REQ-001 SHALL have parameter FIELD_COLS, default 12: field width in cells, including the wall columns 0 and FIELD_COLS-1.
REQ-002 SHALL have parameter FIELD_ROWS, default 22: field height in cells; row FIELD_ROWS-1 is the floor, and rows 0..FIELD_ROWS-2 are playfield.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_res, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_start, input, 1 bit: one-cycle request to scan and clear full rows (issued after a piece locks).
REQ-006 SHALL have port o_busy, output, 1 bit: high while a scan or clear is in progress.
REQ-007 SHALL have port o_done, output, 1 bit: one-cycle pulse when the operation completes.
REQ-008 SHALL have port o_lines, output, 3 bits: count of rows cleared by the last operation; saturates at 7.
REQ-009 SHALL have port o_line_remove_pls, output, 1 bit: one-cycle pulse per cleared row; drives the display line counter.
REQ-010 SHALL have port o_ram_addr, output, 9 bits: field RAM address, computed as y*FIELD_COLS+x.
REQ-011 SHALL have port i_ram_rdata, input, 4 bits: field RAM read data, valid one cycle after the address is presented.
REQ-012 SHALL have port o_ram_we, output, 1 bit: field RAM write enable.
REQ-013 SHALL have port o_ram_wdata, output, 4 bits: field RAM write data.

Function
REQ-014 SHALL treat a cell as occupied when its value is nonzero; a row is full when all of columns 1..FIELD_COLS-2 are occupied.
REQ-015 SHALL implement these states: IDLE, SCAN, CHECK, SHIFT_RD, SHIFT_WR, CLEAR_TOP, DONE.
REQ-016 In IDLE with i_start=1, SHALL set the row pointer r=FIELD_ROWS-2, clear the internal line count, and enter SCAN; i_start SHALL be ignored outside IDLE.
REQ-017 In SCAN, SHALL present columns 1..FIELD_COLS-2 of row r on 10 consecutive cycles, AND the occupied flags one cycle later, then enter CHECK; one row costs 12 cycles including CHECK.
REQ-018 In CHECK, if the row is not full: if r=0, enter DONE; otherwise set r=r-1 and enter SCAN.
REQ-019 In CHECK, if the row is full: pulse o_line_remove_pls in that cycle, increment the count (saturating at 7), set dest y=r, and enter SHIFT_RD.
REQ-020 SHIFT_RD and SHIFT_WR SHALL be two cycles per cell. SHIFT_RD presents address (y-1)*FIELD_COLS+x. SHIFT_WR writes i_ram_rdata to y*FIELD_COLS+x with o_ram_we=1. Column x runs 1..FIELD_COLS-2, then y decrements, down to y=1.
REQ-021 CLEAR_TOP SHALL write 0 to row 0, columns 1..FIELD_COLS-2, one cell per cycle, then return to SCAN with r unchanged so the shifted-down row is rechecked.
REQ-022 SHALL never write wall columns or the floor row; o_ram_we SHALL be 0 in every state except SHIFT_WR and CLEAR_TOP.
REQ-023 A full row at r=0 SHALL skip shifting and go directly to CLEAR_TOP.
REQ-024 DONE SHALL last one cycle: o_done=1 and o_lines is updated; the state then returns to IDLE.
REQ-025 o_lines SHALL hold its value until the next DONE.
REQ-026 o_busy SHALL be 1 in every state except IDLE.
REQ-027 o_busy, o_done, o_line_remove_pls, o_ram_we, o_ram_addr and o_ram_wdata SHALL all be registered outputs.

Reset
REQ-028 While i_res=1 (asserted asynchronously), SHALL be in state IDLE with o_busy=0, o_done=0, o_lines=0, o_line_remove_pls=0, o_ram_we=0, o_ram_addr=0 and o_ram_wdata=0.
REQ-029 Reset during SHIFT_WR or CLEAR_TOP SHALL drop o_ram_we immediately and abandon the operation, with no o_done pulse.

Verification
REQ-030 Empty field, i_start pulse -> no o_line_remove_pls; o_done pulses exactly 252 cycles after the i_start sampling edge; o_lines=0; no writes.
REQ-031 Row 20 full, row 19 holds pattern P -> one o_line_remove_pls; row 20 becomes P; row 0 becomes all zero; o_lines=1; walls unchanged.
REQ-032 Rows 17..20 full, rows 0..16 empty -> four o_line_remove_pls pulses; rows 0..20 all zero at done; o_lines=4.
REQ-033 Rows 20 and 18 full, row 19 partial -> two o_line_remove_pls pulses; final row 20 = old row 19, final row 19 = old row 17; o_lines=2.
REQ-034 i_start re-pulsed while o_busy=1 -> ignored; o_line_remove_pls count and RAM contents are identical to the single-start run.
REQ-035 i_res asserted mid-SHIFT_WR -> o_ram_we=0 in the same cycle; o_busy=0; no o_done; a later i_start runs normally.
